// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch, decode, execute,
// memory and writeback, and stalls on the memory-ready handshake.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [5:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] ALU_SUB = 6'h01;
  localparam logic [5:0] ALU_SLL = 6'h02;
  localparam logic [5:0] ALU_ADD = 6'h04;
  localparam logic [5:0] ALU_AND = 6'h08;
  localparam logic [5:0] ALU_OR  = 6'h10;
  localparam logic [5:0] ALU_R   = 6'h20;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_R_EXEC, S_R_WB,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_BRANCH, S_I_EXEC, S_I_WB, S_JUMP,
    S_JAL, S_JR, S_ILLEGAL
  } state_e;

  state_e state_q, state_d;
  logic [5:0] imm_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:    state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW,
          OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ,
          OP_BNE:  state_d = S_BRANCH;
          OP_ADDI,
          OP_ANDI,
          OP_ORI,
          OP_LUI:  state_d = S_I_EXEC;
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_I_EXEC:   state_d = S_I_WB;
      S_R_WB,
      S_MEM_WB,
      S_BRANCH,
      S_I_WB,
      S_JUMP,
      S_JAL,
      S_JR,
      S_ILLEGAL:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      OP_LUI:  imm_alu = ALU_SLL;
      default: imm_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_op     = 6'h00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_source  = 2'b00;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        // rst_n gate keeps PC/IR frozen while reset is held
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_R;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = 2'b01;
        pc_write   = (opcode == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
      end
      S_I_EXEC, S_I_WB: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = imm_alu;
        imm_zext   = (opcode != OP_ADDI);
        reg_write  = (state_q == S_I_WB);
        instr_done = (state_q == S_I_WB);
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        instr_done = 1'b1;
      end
      S_JR: begin
        alu_op     = ALU_R;
        alu_src_a  = 1'b1;
        pc_source  = 2'b11;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle main control FSM for the MIPS core. Each cycle it drives the 6-bit ALUOp code consumed by the ALU control decoder, along with the datapath select, enable and memory strobes, stepping each instruction through fetch, decode, execute, memory and writeback. It sits between the instruction register (opcode/funct) and the shared datapath, and it stalls on a simple memory-ready handshake.

## Interface
- No parameters; encodings are fixed.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- opcode  in  6  IR[31:26], stable from DECODE until the instruction retires.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, valid in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- alu_op  out  6  0x00 ZER, 0x01 SUB, 0x02 SLL(LUI), 0x04 ADD, 0x08 AND, 0x10 OR, 0x20 R_TYPE.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 imm, 11 imm<<2.
- imm_zext  out  1  1 = zero-extend imm (ANDI/ORI/LUI), 0 = sign-extend.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A (JR).
- pc_write  out  1  PC load enable, already qualified by branch or ready.
- ir_write  out  1  IR load enable.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1  memory strobes.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when the opcode is unsupported.

## Operation
- Moore FSM with a registered state and outputs decoded combinationally from the state. Exception: pc_write/ir_write in FETCH and pc_write in BRANCH are qualified by inputs. Unlisted outputs are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. ir_write and pc_write both equal mem_ready. Holds until mem_ready, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target to ALUOut). Dispatches on opcode:
  - 0x00 → JR if funct==0x08, else R_EXEC.
  - 0x23/0x2B → MEM_ADDR.
  - 0x04/0x05 → BRANCH.
  - 0x08/0x0C/0x0D/0x0F → I_EXEC.
  - 0x02 → JUMP; 0x03 → JAL.
  - anything else → ILLEGAL.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=R_TYPE. Then R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, done. Then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Goes to MEM_RD (0x23) or MEM_WR (0x2B).
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, done. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready; done in the mem_ready cycle, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01. pc_write = zero for 0x04 and ~zero for 0x05. Done, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_op is ADD (0x08), AND (0x0C), OR (0x0D) or SLL (0x0F). imm_zext=1 for 0x0C/0x0D/0x0F. Then I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, done. The I_EXEC ALU selects are held so ALUOut stays valid. Then FETCH.
- JUMP: pc_write=1, pc_source=10, done. Then FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, done. Then FETCH. PC already holds PC+4.
- JR: alu_op=R_TYPE, alu_src_a=1, pc_source=11, pc_write=1, done. Then FETCH.
- ILLEGAL: illegal_op=1, no writes, done. Then FETCH, so the instruction is skipped.

## Timing
- Reset (rst_n low): state=FETCH immediately, asynchronously. Outputs during reset: mem_read=1, alu_op=0x04, alu_src_b=01; all other outputs 0. pc_write/ir_write are forced to 0 while rst_n is low, even if mem_ready=1.
- Reset released mid-instruction: the in-flight instruction is abandoned with no partial write; the FSM restarts at FETCH.
- Latency with zero wait states, in cycles:
  - R-type 4, LW 5, SW 4, I-type 4.
  - BEQ/BNE 3, J/JAL/JR 3, illegal 3.
- Each mem_ready-low cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle. In those cycles all write enables stay 0, except that mem strobes stay asserted.
- mem_ready is ignored in every other state.
- instr_done is high in exactly one cycle per instruction.

## Test plan
- Reset: hold rst_n low with mem_ready=1 → pc_write=0, alu_op=0x04, mem_read=1. Release → FETCH and DECODE next.
- ADD (opcode 0x00, funct 0x20), then JR (funct 0x08), mem_ready tied high:
  - ADD → alu_op=0x20 in R_EXEC; reg_write/reg_dst=01 in cycle 4.
  - JR → pc_source=11, pc_write in cycle 3, no reg_write.
- LW (0x23) with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD → instr_done at cycle 10, single reg_write with mem_to_reg=01.
- BEQ (0x04) with zero=0, then BNE (0x05) with zero=0:
  - BEQ → alu_op=0x01, pc_write=0.
  - BNE → pc_write=1, pc_source=01.
- I-types 0x0F, 0x0C, 0x0D, 0x08 → alu_op 0x02, 0x08, 0x10, 0x04 respectively; imm_zext=1, 1, 1, 0; reg_dst=00.
- Opcode 0x3F → illegal_op pulse in cycle 3, no writes. Separately, JAL (0x03) → reg_dst=10, mem_to_reg=10, pc_write, all in the same cycle. Also assert rst_n low during MEM_WR → mem_write drops immediately and the FSM restarts in FETCH.
